pin_char_tx: RTL and testbench



---
 rtl/io_pkg.sv | 16 +
 rtl/char_fifo.sv | 50 +++++
 rtl/pin_char_tx.sv | 161 ++++++++++++++++
 tb/tb_pin_char_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared pin map and transmitter state encoding for the CPU character-output path.
package io_pkg;

    localparam int CHAR_STROBE_PIN = 0;
    localparam int HALT_PIN        = 1;
    localparam int CHAR_LSB_PIN    = 2;
    localparam int CHAR_BITS       = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/char_fifo.sv
// Power-of-two circular FIFO; pointers carry one extra wrap bit to tell full from empty.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left without reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/pin_char_tx.sv
// Captures strobed characters from the CPU pins into a FIFO and sends them as 8N1 UART frames;
// latches halt and reports done once the last frame has left the wire.
`ifndef BITNESS
`define BITNESS 16
`endif

module pin_char_tx
    import io_pkg::*;
#(
    parameter int BITNESS      = `BITNESS,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITNESS-1:0]       pin_out,
    output logic                     tx,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int DW = $clog2(CLKS_PER_BIT);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic [CHAR_BITS-1:0]   r_sr;
    logic [CHAR_BITS-1:0]   w_sr_next;
    logic [2:0]             r_bitcnt;
    logic [2:0]             w_bitcnt_next;
    logic [DW-1:0]          r_divcnt;
    logic [DW-1:0]          w_divcnt_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   r_halt_seen;
    logic                   r_done;
    logic                   r_overflow;

    logic                   w_strobe;
    logic                   w_halt;
    logic [CHAR_BITS-1:0]   w_char;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CHAR_BITS-1:0]   w_head;
    logic                   w_div_wrap;

    assign w_strobe = pin_out[CHAR_STROBE_PIN];
    assign w_halt   = pin_out[HALT_PIN];
    assign w_char   = pin_out[CHAR_LSB_PIN +: CHAR_BITS];

    generate
        if (BITNESS > CHAR_LSB_PIN + CHAR_BITS) begin : g_spare_pins
            logic w_unused_pins;
            assign w_unused_pins = ^pin_out[BITNESS-1:CHAR_LSB_PIN+CHAR_BITS];
        end
    endgenerate

    // The registered halt flag gates the push, so a strobe arriving with the first halt still lands.
    assign w_push = w_strobe && !r_halt_seen;
    assign w_pop  = (r_state == IDLE) && !w_empty;

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_char),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halt_seen <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_halt_seen <= r_halt_seen | w_halt;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            r_done <= r_halt_seen && w_empty && (r_state == IDLE);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_divcnt <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_sr     <= w_sr_next;
            r_bitcnt <= w_bitcnt_next;
            r_divcnt <= w_divcnt_next;
            r_tx     <= w_tx_next;
        end
    end

    assign w_div_wrap = (r_divcnt == DW'(CLKS_PER_BIT - 1));

    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_sr_next     = r_sr;
        w_bitcnt_next = r_bitcnt;
        w_divcnt_next = r_divcnt;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_next  = START;
                    w_sr_next     = w_head;
                    w_bitcnt_next = '0;
                    w_divcnt_next = '0;
                end
            end
            START: begin
                w_divcnt_next = w_div_wrap ? '0 : r_divcnt + DW'(1);
                if (w_div_wrap) w_state_next = DATA;
            end
            DATA: begin
                w_divcnt_next = w_div_wrap ? '0 : r_divcnt + DW'(1);
                if (w_div_wrap) begin
                    w_sr_next     = r_sr >> 1;
                    w_bitcnt_next = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_next = STOP;
                end
            end
            STOP: begin
                w_divcnt_next = w_div_wrap ? '0 : r_divcnt + DW'(1);
                if (w_div_wrap) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line level is decoded from the next state so the registered tx lines up with the state it reflects.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_sr_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign busy     = (r_state != IDLE) || !w_empty;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_pin_char_tx.sv
// Directed bench for pin_char_tx: a line monitor decodes 8N1 frames, each test task checks its own scenario.
module tb_pin_char_tx;

    localparam int BITNESS = 16;
    localparam int DEPTH   = 4;
    localparam int CPB     = 4;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [BITNESS-1:0] pin_out = '0;
    logic               tx;
    logic               busy;
    logic               done;
    logic               overflow;
    logic [LW-1:0]      level;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         framing_ok;
    } frame_t;

    frame_t q[$];

    pin_char_tx #(
        .BITNESS      (BITNESS),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pin_out  (pin_out),
        .tx       (tx),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: start seen at offset 0, mid-start at 2, data bit k at 6+4k, mid-stop at 38.
    initial begin : monitor
        frame_t f;
        bit     live;
        forever begin
            @(posedge clk); #2;
            if (rst === 1'b1 && tx === 1'b0) begin
                f.start      = cyc;
                f.data       = '0;
                f.framing_ok = 1'b1;
                live         = 1'b1;
                for (int c = 1; c <= 38; c++) begin
                    @(posedge clk); #2;
                    if (rst !== 1'b1) begin
                        live = 1'b0;
                        break;
                    end
                    if (c == 2 && tx !== 1'b0) f.framing_ok = 1'b0;
                    if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) f.data[(c - 6) / 4] = tx;
                    if (c == 38 && tx !== 1'b1) f.framing_ok = 1'b0;
                end
                if (live) q.push_back(f);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive(input logic [7:0] ch, input bit strobe, input bit halt);
        pin_out      = '0;
        pin_out[9:2] = ch;
        pin_out[0]   = strobe;
        pin_out[1]   = halt;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        pin_out = '0;
        tick(2);
        q.delete();
        rst = 1'b1;
        tick(1);
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: frames %0d required %0d", name, q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(2);
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (level !== 3'd0)    begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_single_a();
        logic [7:0]  ch = 8'h41;
        logic [39:0] obs;
        logic [39:0] expv;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       expv[i] = 1'b0;
            else if (i < 36) expv[i] = ch[(i - 4) / 4];
            else             expv[i] = 1'b1;
        end
        q.delete();
        drive(ch, 1'b1, 1'b0);
        tick();
        pin_out = '0;
        checks++;
        if (level !== 3'd1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_capture: level %0d tx %b want level 1 tx 1", level, tx);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            obs[i] = tx;
        end
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL single_wave: got %h want %h", obs, expv);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_in_stop: got %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
        checks++;
        if (q.size() != 1 || q[0].data !== 8'h41 || !q[0].framing_ok) begin
            errors++;
            $display("FAIL single_decode: frames %0d got %h want 41", q.size(), (q.size() > 0) ? q[0].data : 8'hxx);
        end
    endtask

    task automatic test_burst();
        logic [7:0] chars [3] = '{8'h48, 8'h69, 8'h0A};
        int peak = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(chars[i], 1'b1, 1'b0);
            tick();
            if (int'(level) > peak) peak = int'(level);
        end
        pin_out = '0;
        tick();
        if (int'(level) > peak) peak = int'(level);
        wait_frames(3, 300, "burst");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= q.size() || q[i].data !== chars[i] || !q[i].framing_ok) begin
                errors++;
                $display("FAIL burst_byte%0d: got %h want %h", i, (i < q.size()) ? q[i].data : 8'hxx, chars[i]);
            end
        end
        if (q.size() >= 3) begin
            checks++;
            if (q[1].start - q[0].start != 41 || q[2].start - q[1].start != 41) begin
                errors++;
                $display("FAIL burst_spacing: got %0d,%0d want 41,41", q[1].start - q[0].start, q[2].start - q[1].start);
            end
        end
        checks++; if (peak != 2)         begin errors++; $display("FAIL burst_peak_level: got %0d want 2", peak); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(8'h30 + 8'(i), 1'b1, 1'b0);
            tick();
        end
        pin_out = '0;
        checks++; if (level !== 3'd4)    begin errors++; $display("FAIL ovf_level: got %0d want 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        wait_frames(5, 400, "ovf");
        tick(60);
        checks++; if (q.size() != 5) begin errors++; $display("FAIL ovf_frame_count: got %0d want 5", q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= q.size() || q[i].data !== 8'h30 + 8'(i) || !q[i].framing_ok) begin
                errors++;
                $display("FAIL ovf_byte%0d: got %h want %h", i, (i < q.size()) ? q[i].data : 8'hxx, 8'h30 + 8'(i));
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_halt();
        int k = 0;
        do_reset();
        drive(8'h5A, 1'b1, 1'b1);
        tick();
        drive(8'h31, 1'b1, 1'b0);
        tick();
        pin_out = '0;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL halt_done_timeout: done %b want 1", done);
        end else if (q.size() < 1 || cyc != q[0].start + 41) begin
            errors++;
            $display("FAIL halt_done_timing: done at %0d want %0d", cyc, (q.size() > 0) ? q[0].start + 41 : -1);
        end
        tick(60);
        checks++;
        if (q.size() != 1 || q[0].data !== 8'h5A || !q[0].framing_ok) begin
            errors++;
            $display("FAIL halt_frames: count %0d first %h want 1 frame of 5a", q.size(), (q.size() > 0) ? q[0].data : 8'hxx);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL halt_overflow: got %b want 0", overflow); end
        checks++; if (done !== 1'b1)     begin errors++; $display("FAIL halt_done_held: got %b want 1", done); end
    endtask

    task automatic test_reset_mid();
        bit tx_high = 1'b1;
        do_reset();
        drive(8'h11, 1'b1, 1'b0); tick();
        drive(8'h22, 1'b1, 1'b0); tick();
        drive(8'h33, 1'b1, 1'b0); tick();
        pin_out = '0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL mid_level_before: got %0d want 2", level); end
        // Frame started one edge after the first strobe; 15 more edges land at the start of data bit 3 (a 0 for 0x11).
        tick(15);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b want 0", tx); end
        rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL mid_reset_tx: got %b want 1", tx); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_reset_level: got %0d want 0", level); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        tick(2);
        q.delete();
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1) tx_high = 1'b0;
        end
        checks++; if (!tx_high)     begin errors++; $display("FAIL mid_release_idle: tx dropped, want held 1"); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL mid_release_frames: got %0d want 0", q.size()); end
    endtask

    task automatic test_halt_only();
        bit tx_high = 1'b1;
        do_reset();
        drive(8'h00, 1'b0, 1'b1);
        tick();
        pin_out = '0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL haltonly_done_early: got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL haltonly_done: got %b want 1", done); end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1) tx_high = 1'b0;
        end
        checks++; if (!tx_high)     begin errors++; $display("FAIL haltonly_tx: tx dropped, want held 1"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL haltonly_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_burst();
        test_overflow();
        test_halt();
        test_reset_mid();
        test_halt_only();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
